// File: rtl/analyser_frame_controller_if.sv
// analyser_frame_controller_if: sample intake and frame-result handshake bundle
//   master: drives sample/sample_valid/result_ready (codec reader + consumer side)
//   slave : drives result_valid/pitch/volumn/peak (frame controller side)
interface analyser_frame_controller_if #(
   parameter int SAMPLE_W = 24
);
   logic [SAMPLE_W-1:0] sample;
   logic                sample_valid;
   logic                result_valid;
   logic                result_ready;
   logic [1:0]          pitch;
   logic                volumn;
   logic [SAMPLE_W-1:0] peak;
   modport master (output sample, sample_valid, result_ready, input result_valid, pitch, volumn, peak);
   modport slave  (input sample, sample_valid, result_ready, output result_valid, pitch, volumn, peak);
endinterface

// File: rtl/analyser_frame_controller.sv
// analyser_frame_controller: aligns sample strobes into fixed-length frames, classifies
// pitch (zero-crossing count) and volume (peak magnitude), publishes one result per frame.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   enable_i       - run request; low returns to IDLE and discards the partial frame
//   bus (slave)    - sample/sample_valid in; result_valid/result_ready handshake with
//                    pitch (00 low, 01 mid, 11 high), volumn (loud flag), peak (frame peak)
//   overrun_o      - sticky: an unaccepted result was overwritten (cleared by reset only)
//   state_dbg_o    - FSM state (IDLE=00, SYNC=01, RUN=10)
// Optional: define PITCH_HYST_EN to publish a new pitch only after two consecutive
// frames agree on it.
module analyser_frame_controller #(
   parameter int                  SAMPLE_W   = 24,
   parameter int                  FRAME_LEN  = 800,
   parameter int                  LOW_XING   = 6,
   parameter int                  HIGH_XING  = 12,
   parameter logic [SAMPLE_W-1:0] VOL_THRESH = 24'h3FFFFF
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable_i,
   analyser_frame_controller_if.slave   bus,
   output logic                         overrun_o,
   output logic [1:0]                   state_dbg_o
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
   localparam logic [SAMPLE_W-1:0] MAX_POS  = {1'b0, {(SAMPLE_W-1){1'b1}}};
   typedef enum logic [1:0] {IDLE = 2'b00, SYNC = 2'b01, RUN = 2'b10} state_t;
   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d, xing_q, xing_d, cnt_inc, xing_inc;
   logic [SAMPLE_W-1:0] peak_acc_q, peak_acc_d, mag, peak_max;
   logic                prev_sign_q, prev_sign_d;
   logic                valid_q, valid_d, vol_q, vol_d, overrun_q, overrun_d;
   logic [1:0]          pitch_q, pitch_d, raw_pitch, pub_pitch;
   logic [SAMPLE_W-1:0] peak_q, peak_d;
   logic                sgn, rise, close;
   assign sgn      = bus.sample[SAMPLE_W-1];
   // the most-negative code has no positive twin, so it clamps instead of wrapping
   assign mag      = !sgn ? bus.sample : (bus.sample == MOST_NEG) ? MAX_POS : -bus.sample;
   assign rise     = prev_sign_q & ~sgn;
   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign xing_inc = (rise && !(&xing_q)) ? xing_q + CNT_W'(1) : xing_q;
   assign peak_max = (mag > peak_acc_q) ? mag : peak_acc_q;
   assign close    = state_q == RUN && enable_i && bus.sample_valid && cnt_inc == CNT_W'(FRAME_LEN);
   assign raw_pitch = (xing_inc >= CNT_W'(HIGH_XING)) ? 2'b11 :
                      (xing_inc >= CNT_W'(LOW_XING))  ? 2'b01 : 2'b00;
`ifdef PITCH_HYST_EN
   logic       first_q, first_d;
   logic [1:0] prev_raw_q, prev_raw_d;
   assign pub_pitch  = (first_q || raw_pitch == prev_raw_q) ? raw_pitch : pitch_q;
   assign first_d    = (state_q == IDLE) ? 1'b1 : close ? 1'b0 : first_q;
   assign prev_raw_d = close ? raw_pitch : prev_raw_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         first_q    <= 1'b1;
         prev_raw_q <= 2'b00;
      end else begin
         first_q    <= first_d;
         prev_raw_q <= prev_raw_d;
      end
   end
`else
   assign pub_pitch = raw_pitch;
`endif
   always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
   always_comb
      state_d = !enable_i ? IDLE :
                (state_q == IDLE) ? SYNC :
                (state_q == SYNC && bus.sample_valid && rise) ? RUN : state_q;
   always_comb begin
      cnt_d       = cnt_q;
      xing_d      = xing_q;
      peak_acc_d  = peak_acc_q;
      prev_sign_d = prev_sign_q;
      if (state_q == IDLE || !enable_i) begin
         cnt_d       = '0;
         xing_d      = '0;
         peak_acc_d  = '0;
         prev_sign_d = 1'b0;
      end else if (bus.sample_valid) begin
         prev_sign_d = sgn;
         // the sync sample opens the frame; its own crossing is not counted
         if (state_q == SYNC && rise) begin
            cnt_d      = CNT_W'(1);
            xing_d     = '0;
            peak_acc_d = mag;
         end else if (state_q == RUN) begin
            cnt_d      = close ? '0 : cnt_inc;
            xing_d     = close ? '0 : xing_inc;
            peak_acc_d = close ? '0 : peak_max;
         end
      end
      // a closing frame keeps valid high even when the old result is accepted this cycle
      valid_d   = close | (valid_q & ~bus.result_ready);
      overrun_d = overrun_q | (close & valid_q & ~bus.result_ready);
      pitch_d   = close ? pub_pitch : pitch_q;
      vol_d     = close ? (peak_max >= VOL_THRESH) : vol_q;
      peak_d    = close ? peak_max : peak_q;
      state_dbg_o      = state_q;
      bus.result_valid = valid_q;
      bus.pitch        = pitch_q;
      bus.volumn       = vol_q;
      bus.peak         = peak_q;
      overrun_o        = overrun_q;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         xing_q      <= '0;
         peak_acc_q  <= '0;
         prev_sign_q <= 1'b0;
         valid_q     <= 1'b0;
         overrun_q   <= 1'b0;
         pitch_q     <= 2'b00;
         vol_q       <= 1'b0;
         peak_q      <= '0;
      end else begin
         cnt_q       <= cnt_d;
         xing_q      <= xing_d;
         peak_acc_q  <= peak_acc_d;
         prev_sign_q <= prev_sign_d;
         valid_q     <= valid_d;
         overrun_q   <= overrun_d;
         pitch_q     <= pitch_d;
         vol_q       <= vol_d;
         peak_q      <= peak_d;
      end
   end
endmodule

// File: tb/tb_analyser_frame_controller.sv
// tb_analyser_frame_controller: randomized frame stimulus checked against a queue-based frame model
module tb_analyser_frame_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       overrun;
   logic [1:0] state_dbg;
   int         n_pass = 0;
   int         n_total = 0;
   analyser_frame_controller_if bus ();
   analyser_frame_controller dut (
      .clk(clk), .reset(reset), .enable_i(enable), .bus(bus),
      .overrun_o(overrun), .state_dbg_o(state_dbg)
   );
   always #5 clk = ~clk;
   logic [1:0]         m_state;
   bit                 m_prev, m_lead, m_valid, m_over, m_vol, m_closed, m_hfirst;
   logic [1:0]         m_pitch, m_hraw;
   logic [23:0]        m_peak;
   logic signed [23:0] m_frame[$];
   int                 g_idx;
   function automatic logic [30:0] dut_v();
      return {bus.result_valid, bus.pitch, bus.volumn, bus.peak, overrun, state_dbg};
   endfunction
   function automatic logic [30:0] exp_v();
      return {m_valid, m_pitch, m_vol, m_peak, m_over, m_state};
   endfunction
   // Whole-frame evaluation from the stored samples of the frame.
   task automatic close_frame();
      int xing = 0, pk = 0, v;
      bit p;
      logic [1:0] raw;
      for (int i = 0; i < m_frame.size(); i++) begin
         p = (i == 0) ? m_lead : m_frame[i-1][23];
         if (p && !m_frame[i][23]) xing++;
         v = int'(m_frame[i]);
         v = (v < 0) ? -v : v;
         if (v > 8388607) v = 8388607;
         if (v > pk) pk = v;
      end
      raw = (xing >= 12) ? 2'b11 : (xing >= 6) ? 2'b01 : 2'b00;
`ifdef PITCH_HYST_EN
      if (m_hfirst || raw == m_hraw) m_pitch = raw;
      m_hraw = raw;
      m_hfirst = 0;
`else
      m_pitch = raw;
`endif
      m_vol = pk >= 'h3FFFFF;
      m_peak = pk[23:0];
      m_lead = m_frame[m_frame.size()-1][23];
      m_frame.delete();
      m_closed = 1;
   endtask
   // Advances the model by one clock using the inputs currently driven, then the clock itself.
   task automatic tick();
      bit acc, sg;
      m_closed = 0;
      if (reset) begin
         m_state = 0; m_prev = 0; m_frame.delete(); m_valid = 0; m_over = 0;
         m_pitch = 0; m_vol = 0; m_peak = 0; m_hfirst = 1;
      end else begin
         acc = m_valid && bus.result_ready;
         sg = bus.sample[23];
         if (!enable) begin
            m_state = 0; m_prev = 0; m_frame.delete();
         end else if (m_state == 0) m_state = 1;
         else if (bus.sample_valid) begin
            if (m_state == 1) begin
               if (m_prev && !sg) begin m_state = 2; m_frame = {bus.sample}; m_lead = 0; end
            end else begin
               m_frame.push_back(bus.sample);
               if (m_frame.size() == 800) close_frame();
            end
            m_prev = sg;
         end
         if (m_state == 0) m_hfirst = 1;
         if (m_closed) begin m_over = m_over | (m_valid && !bus.result_ready); m_valid = 1; end
         else if (acc) m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic restart();
      reset = 1; enable = 0; bus.result_ready = 1; bus.sample_valid = 0;
      tick();
      reset = 0; enable = 1;
      tick();
   endtask
   // kind 0: square wave, 1: random full-range samples, 2: square wave with one most-negative sample
   task automatic run_frame(int kind, int period, int amp, int stop_at, bit ready_at_close);
      logic [23:0] s;
      int inj = $urandom_range(100, 700);
      for (int n = 0; n < 5000; n++) begin
         repeat ($urandom_range(0, 2)) tick();
         s = (kind == 1) ? 24'($urandom) : ((g_idx % period) < period / 2) ? 24'(amp) : 24'(-amp);
         g_idx++;
         if (kind == 2 && m_state == 2 && m_frame.size() == inj) s = 24'h800000;
         if (ready_at_close && m_state == 2 && m_frame.size() == 799) bus.result_ready = 1;
         bus.sample = s; bus.sample_valid = 1;
         tick();
         bus.sample_valid = 0; bus.sample = 24'($urandom);
         if (m_closed) break;
         if (stop_at > 0 && m_state == 2 && m_frame.size() == stop_at) break;
      end
   endtask
   task automatic test_reset();
      bus.sample = 0; bus.sample_valid = 0; bus.result_ready = 1;
      reset = 1; tick(); reset = 0;
      n_total++; if (dut_v() !== 31'd0) $display("FAIL reset_values got %h exp %h", dut_v(), 31'd0); else n_pass++;
      tick();
      n_total++; if (state_dbg !== 2'b00) $display("FAIL idle_hold got %b exp 00", state_dbg); else n_pass++;
      enable = 1; bus.sample_valid = 1; bus.sample = 24'h000010;
      tick();
      bus.sample_valid = 0;
      n_total++; if (state_dbg !== 2'b01) $display("FAIL idle_to_sync got %b exp 01", state_dbg); else n_pass++;
   endtask
   task automatic test_square();
      int per[3] = '{100, 50, 200};
      int amp[3] = '{'h400000, 'h100000, 'h400000};
      logic [25:0] fix[3] = '{{2'b01, 24'h400000}, {2'b11, 24'h100000}, {2'b00, 24'h400000}};
      bit vol[3] = '{1, 0, 1};
      for (int i = 0; i < 3; i++) begin
         restart(); g_idx = per[i] / 2;
         run_frame(0, per[i], amp[i], 0, 0);
         n_total++; if (dut_v() !== exp_v()) $display("FAIL sq_frame1 p%0d got %h exp %h", per[i], dut_v(), exp_v()); else n_pass++;
         n_total++; if ({bus.result_valid, bus.pitch, bus.peak, bus.volumn} !== {1'b1, fix[i], vol[i]})
            $display("FAIL sq_fixed p%0d got %h exp %h", per[i], {bus.result_valid, bus.pitch, bus.peak, bus.volumn}, {1'b1, fix[i], vol[i]}); else n_pass++;
         tick();
         n_total++; if (dut_v() !== exp_v()) $display("FAIL sq_valid_drop p%0d got %h exp %h", per[i], dut_v(), exp_v()); else n_pass++;
         run_frame(0, per[i], amp[i], 0, 0);
         n_total++; if (dut_v() !== exp_v()) $display("FAIL sq_frame2 p%0d got %h exp %h", per[i], dut_v(), exp_v()); else n_pass++;
      end
   endtask
   task automatic test_most_negative();
      restart(); g_idx = 25;
      run_frame(2, 50, 'h100000, 0, 0);
      n_total++; if (dut_v() !== exp_v()) $display("FAIL mostneg_model got %h exp %h", dut_v(), exp_v()); else n_pass++;
      n_total++; if ({bus.peak, bus.volumn} !== {24'h7FFFFF, 1'b1}) $display("FAIL mostneg_sat got %h exp %h", {bus.peak, bus.volumn}, {24'h7FFFFF, 1'b1}); else n_pass++;
   endtask
   task automatic test_random();
      restart();
      for (int f = 0; f < 2; f++) begin
         run_frame(1, 1, 0, 0, 0);
         n_total++; if (dut_v() !== exp_v()) $display("FAIL random_frame%0d got %h exp %h", f, dut_v(), exp_v()); else n_pass++;
      end
   endtask
   task automatic test_back_to_back();
      restart(); g_idx = 50; bus.result_ready = 0;
      run_frame(0, 100, 'h400000, 0, 0);
      repeat (5) tick();
      n_total++; if (dut_v() !== exp_v()) $display("FAIL b2b_held got %h exp %h", dut_v(), exp_v()); else n_pass++;
      run_frame(0, 100, 'h400000, 0, 1);
      n_total++; if (dut_v() !== exp_v()) $display("FAIL b2b_accept_close got %h exp %h", dut_v(), exp_v()); else n_pass++;
      n_total++; if ({bus.result_valid, overrun} !== 2'b10) $display("FAIL b2b_no_overrun got %b exp 10", {bus.result_valid, overrun}); else n_pass++;
      tick();
      n_total++; if (bus.result_valid !== 1'b0) $display("FAIL b2b_drop got %b exp 0", bus.result_valid); else n_pass++;
   endtask
   task automatic test_overrun();
      restart(); g_idx = 25; bus.result_ready = 0;
      run_frame(0, 50, 'h100000, 0, 0);
      run_frame(0, 50, 'h100000, 0, 0);
      n_total++; if (dut_v() !== exp_v()) $display("FAIL ovr_second got %h exp %h", dut_v(), exp_v()); else n_pass++;
      n_total++; if ({bus.result_valid, overrun} !== 2'b11) $display("FAIL ovr_flag got %b exp 11", {bus.result_valid, overrun}); else n_pass++;
      bus.result_ready = 1;
      repeat (4) tick();
      n_total++; if (dut_v() !== exp_v()) $display("FAIL ovr_sticky got %h exp %h", dut_v(), exp_v()); else n_pass++;
   endtask
   task automatic test_enable_drop();
      restart(); g_idx = 50;
      run_frame(0, 100, 'h400000, 400, 0);
      enable = 0;
      tick();
      n_total++; if (dut_v() !== exp_v()) $display("FAIL en_drop got %h exp %h", dut_v(), exp_v()); else n_pass++;
      n_total++; if ({bus.result_valid, state_dbg} !== 3'b000) $display("FAIL en_idle got %b exp 000", {bus.result_valid, state_dbg}); else n_pass++;
      bus.sample_valid = 1; bus.sample = 24'h000001;
      repeat (3) tick();
      bus.sample_valid = 0;
      enable = 1;
      tick();
      n_total++; if (state_dbg !== 2'b01) $display("FAIL en_resync got %b exp 01", state_dbg); else n_pass++;
      g_idx = 50;
      run_frame(0, 100, 'h400000, 0, 0);
      n_total++; if (dut_v() !== exp_v()) $display("FAIL en_new_frame got %h exp %h", dut_v(), exp_v()); else n_pass++;
   endtask
   task automatic test_reset_mid();
      restart(); g_idx = 25; bus.result_ready = 0;
      run_frame(0, 50, 'h400000, 0, 0);
      run_frame(0, 50, 'h400000, 0, 0);
      run_frame(0, 50, 'h400000, 500, 0);
      n_total++; if (dut_v() !== exp_v()) $display("FAIL rstmid_before got %h exp %h", dut_v(), exp_v()); else n_pass++;
      reset = 1;
      tick();
      reset = 0;
      n_total++; if ({bus.result_valid, overrun, state_dbg} !== 4'b0000) $display("FAIL rstmid_after got %b exp 0000", {bus.result_valid, overrun, state_dbg}); else n_pass++;
      n_total++; if (dut_v() !== exp_v()) $display("FAIL rstmid_model got %h exp %h", dut_v(), exp_v()); else n_pass++;
      bus.result_ready = 1;
   endtask
   task automatic test_hyst();
      int per[2][3] = '{'{100, 50, 100}, '{100, 50, 50}};
`ifdef PITCH_HYST_EN
      logic [1:0] ep[2][3] = '{'{2'b01, 2'b01, 2'b01}, '{2'b01, 2'b01, 2'b11}};
`else
      logic [1:0] ep[2][3] = '{'{2'b01, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b11}};
`endif
      for (int s = 0; s < 2; s++) begin
         restart(); g_idx = 50;
         for (int f = 0; f < 3; f++) begin
            run_frame(0, per[s][f], 'h400000, 0, 0);
            n_total++; if (dut_v() !== exp_v()) $display("FAIL hyst_model s%0d f%0d got %h exp %h", s, f, dut_v(), exp_v()); else n_pass++;
            n_total++; if (bus.pitch !== ep[s][f]) $display("FAIL hyst_pitch s%0d f%0d got %b exp %b", s, f, bus.pitch, ep[s][f]); else n_pass++;
         end
      end
   endtask
   initial begin
      test_reset();
      test_square();
      test_most_negative();
      test_random();
      test_back_to_back();
      test_overrun();
      test_enable_drop();
      test_reset_mid();
      test_hyst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
